fifo_read_ctrl: RTL and testbench

- Read-side controller for the 512-entry FIFO memory array.
- Compares the write pointer against its own read pointer and generates `rptr` and `fifo_rd`.
- Absorbs the array's 1-cycle registered read latency in a 2-entry output buffer.
- Presents words to the downstream consumer on a valid/ready stream; it is the reader counterpart to the write-pointer logic.

---
 rtl/fifo_read_ctrl.sv | 113 +++++++++++
 tb/tb_fifo_read_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: read-side controller for a 512-entry FIFO array.
// Issues array reads against the write pointer, absorbs the array's
// one-cycle registered read latency in a two-entry output buffer, and
// presents words to the consumer on a valid/ready stream.
module fifo_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int PTR_WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PTR_WIDTH-1:0]  wptr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  flush,
  output logic [PTR_WIDTH-1:0]  rptr,
  output logic                  fifo_rd,
  output logic                  fifo_empty,
  output logic [PTR_WIDTH-1:0]  rd_level,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  ptr_err
);

  // Threshold above which the write side must have lapped the reader.
  localparam logic [PTR_WIDTH-1:0] LVL_MAX = {1'b1, {(PTR_WIDTH-1){1'b0}}};

  logic [PTR_WIDTH-1:0]  r_rptr;
  logic                  r_inflight;
  logic [1:0]            r_cnt;
  logic [DATA_WIDTH-1:0] r_buf0;
  logic [DATA_WIDTH-1:0] r_buf1;
  logic                  r_ptr_err;

  logic                  w_empty;
  logic [PTR_WIDTH-1:0]  w_level;
  logic [1:0]            w_slots;
  logic                  w_pop;
  logic                  w_cap;
  logic                  w_rd;

  // Occupancy bookkeeping and the read-issue decision. A read is only
  // issued when the word it returns is guaranteed a buffer slot, counting
  // the word already in flight and any slot freed by this cycle's pop.
  always_comb begin
    w_empty = (wptr == r_rptr);
    w_level = wptr - r_rptr;
    w_slots = r_cnt + {1'b0, r_inflight};
    w_pop   = (r_cnt != 2'd0) & m_ready;
    w_cap   = r_inflight;
    w_rd    = !w_empty & !flush & !rst &
              ((w_slots < 2'd2) | ((w_slots == 2'd2) & w_pop));
  end

  // Read pointer, in-flight marker and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr     <= '0;
      r_inflight <= 1'b0;
      r_ptr_err  <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (flush)
        r_rptr <= wptr;
      else if (w_rd)
        r_rptr <= r_rptr + 1'b1;
      if (w_level > LVL_MAX)
        r_ptr_err <= 1'b1;
    end
  end

  // Two-entry output buffer: buf0 is the head shown on m_data, buf1 the
  // entry behind it. Flush drops everything including an arriving word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 2'd0;
      r_buf0 <= '0;
    end else if (flush) begin
      r_cnt <= 2'd0;
    end else begin
      case ({w_pop, w_cap})
        2'b11: begin
          if (r_cnt == 2'd2) begin
            r_buf0 <= r_buf1;
            r_buf1 <= mem_rdata;
          end else begin
            r_buf0 <= mem_rdata;
          end
        end
        2'b10: begin
          r_buf0 <= r_buf1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b01: begin
          if (r_cnt == 2'd0)
            r_buf0 <= mem_rdata;
          else
            r_buf1 <= mem_rdata;
          r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign rptr       = r_rptr;
  assign fifo_rd    = w_rd;
  assign fifo_empty = w_empty;
  assign rd_level   = w_level;
  assign m_valid    = (r_cnt != 2'd0);
  assign m_data     = r_buf0;
  assign ptr_err    = r_ptr_err;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: models the registered FIFO array, pushes each
// written word onto an expected queue, and a monitor compares every word
// the consumer accepts against the queue head.
module tb_fifo_read_ctrl;
  localparam int DW = 32;
  localparam int PW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW-1:0] wptr;
  logic [DW-1:0] mem_rdata;
  logic          flush;
  logic [PW-1:0] rptr;
  logic          fifo_rd;
  logic          fifo_empty;
  logic [PW-1:0] rd_level;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          ptr_err;

  logic [DW-1:0] mem [0:511];
  logic [DW-1:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;
  int vcnt, run, best, rdcnt;

  always #5 clk = ~clk;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .PTR_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .wptr(wptr), .mem_rdata(mem_rdata), .flush(flush),
    .rptr(rptr), .fifo_rd(fifo_rd), .fifo_empty(fifo_empty),
    .rd_level(rd_level), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .ptr_err(ptr_err)
  );

  // Array model: registered read, data valid the cycle after fifo_rd.
  always @(posedge clk) if (fifo_rd) mem_rdata <= mem[rptr[8:0]];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] d);
    mem[wptr[8:0]] = d;
    wptr = wptr + 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic monitor();
    logic [DW-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && !flush && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL stream_extra: got word %0h expected none", m_data);
        end else begin
          e = exp_q.pop_front();
          check("stream_data", m_data, e);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; m_ready = 1'b0; wptr = '0;
    for (int i = 0; i < 512; i++) mem[i] = '0;
    fork monitor(); join_none

    // Reset state
    step(); step(); neg();
    check("rst_rptr", rptr, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_ptr_err", ptr_err, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_empty", fifo_empty, 1);
    step(); rst = 1'b0; m_ready = 1'b1; neg();

    // Single word
    step(); push(32'hA5A5_0001); neg();
    check("sw_fifo_rd_c0", fifo_rd, 1);
    check("sw_level_c0", rd_level, 1);
    step(); neg();
    check("sw_rptr_c1", rptr, 1);
    check("sw_empty_c1", fifo_empty, 1);
    check("sw_valid_c1", m_valid, 0);
    step(); neg();
    check("sw_valid_c2", m_valid, 1);
    step(); neg();
    check("sw_valid_c3", m_valid, 0);

    // Streaming, 8 words back-to-back
    vcnt = 0; run = 0; best = 0;
    for (int k = 0; k < 14; k++) begin
      step();
      if (k < 8) push(32'h0000_1000 + k);
      neg();
      if (m_valid) begin
        vcnt++; run++;
        if (run > best) best = run;
      end else run = 0;
    end
    check("st_valid_cycles", vcnt, 8);
    check("st_valid_run", best, 8);
    check("st_rptr", rptr, 9);
    check("st_level", rd_level, 0);
    check("st_drained", exp_q.size(), 0);

    // Backpressure
    step(); m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(32'h0000_2000 + i);
    rdcnt = 0;
    neg(); rdcnt += int'(fifo_rd);
    for (int c = 1; c < 5; c++) begin
      step(); neg();
      rdcnt += int'(fifo_rd);
      if (c >= 2) begin
        check("bp_valid", m_valid, 1);
        check("bp_hold", m_data, exp_q[0]);
      end
    end
    check("bp_rd_pulses", rdcnt, 2);
    check("bp_level", rd_level, 2);
    step(); m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin step(); neg(); end
    check("bp_drained", exp_q.size(), 0);
    check("bp_level_end", rd_level, 0);
    check("bp_rptr", rptr, 13);

    // Wrap-around from 510
    step(); wptr = 10'd510; flush = 1'b1; neg();
    check("wr_flush_rd", fifo_rd, 0);
    step(); flush = 1'b0; neg();
    check("wr_rptr_pre", rptr, 510);
    check("wr_empty_pre", fifo_empty, 1);
    for (int k = 0; k < 5; k++) begin
      step();
      if (k < 4) push(32'h0000_3000 + k);
      neg();
      check("wr_rptr", rptr, 510 + k);
    end
    check("wr_empty_end", fifo_empty, 1);
    for (int c = 0; c < 4; c++) begin step(); neg(); end
    check("wr_drained", exp_q.size(), 0);

    // Flush mid-stream with a read in flight
    step();
    for (int i = 0; i < 6; i++) push(32'h0000_4000 + i);
    neg();
    step(); neg();
    step(); neg();
    step(); neg();
    step(); flush = 1'b1; m_ready = 1'b0; neg();
    check("fl_fifo_rd", fifo_rd, 0);
    check("fl_consumed", exp_q.size(), 4);
    step(); flush = 1'b0; exp_q.delete(); m_ready = 1'b1; neg();
    check("fl_rptr_eq_wptr", rptr, wptr);
    check("fl_valid", m_valid, 0);
    check("fl_empty", fifo_empty, 1);
    step(); neg();
    check("fl_valid_c2", m_valid, 0);
    step(); neg();
    check("fl_valid_c3", m_valid, 0);

    // Overrun, then reset with a full buffer
    step(); m_ready = 1'b0; wptr = rptr + 10'd513; neg();
    check("ov_level", rd_level, 513);
    step(); neg();
    check("ov_err_set", ptr_err, 1);
    step(); neg();
    step(); neg();
    check("ov_err_sticky", ptr_err, 1);
    check("ov_buf_full", m_valid, 1);
    step(); rst = 1'b1; wptr = '0; neg();
    check("ov_rst_rd", fifo_rd, 0);
    step(); rst = 1'b0; exp_q.delete(); neg();
    check("ov_rst_err", ptr_err, 0);
    check("ov_rst_valid", m_valid, 0);
    check("ov_rst_rptr", rptr, 0);
    check("ov_rst_data", m_data, 0);
    check("ov_rst_empty", fifo_empty, 1);
    step(); neg();
    check("ov_rst_valid_c2", m_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
